// File: rtl/cl_frame_capture.sv
// Camera Link frame capture: qualifies FVAL/LVAL beats, tags SOF/SOL/EOL and
// queues them in a first-word-fall-through FIFO with frame geometry reporting.
module cl_frame_capture #(
   parameter int FIFO_AW = 4,
   parameter int PIX_W   = 12,
   parameter int LINE_W  = 12
) (
   input  logic              cl_x_pclk,
   input  logic              reset,
   input  logic              cl_fval,
   input  logic              cl_x_lval,
   input  logic [7:0]        cl_port_a,
   input  logic [7:0]        cl_port_b,
   input  logic [7:0]        cl_port_c,
   input  logic [7:0]        cl_port_d,
   input  logic [7:0]        cl_port_e,
   input  logic [7:0]        cl_port_f,
   input  logic [7:0]        cl_port_g,
   input  logic [7:0]        cl_port_h,
   input  logic [7:0]        cl_port_i,
   input  logic [7:0]        cl_port_j,
   output logic [79:0]       out_data,
   output logic              out_sof,
   output logic              out_sol,
   output logic              out_eol,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [PIX_W-1:0]  line_pixels,
   output logic [LINE_W-1:0] frame_lines,
   output logic [7:0]        frame_count,
   output logic              overflow,
   output logic [7:0]        led8
);

   localparam int DEPTH = 1 << FIFO_AW;
   localparam int EW    = 83;

   typedef enum logic [1:0] {SYNC = 2'd0, IDLE = 2'd1, FRAME = 2'd2, DROP = 2'd3} state_t;

   state_t              state, state_n;
   logic [1:0]          state_bits;
   logic                r_fval, r_lval, beat;
   logic [79:0]         r_data, s_data;
   logic                s_full, s_sof, s_sol, sof_arm, sof_now;
   logic                load_s, wr_en, wr_fail, frame_done, eol_wr;
   logic [FIFO_AW:0]    wr_ptr, rd_ptr;
   logic                empty, full, pop, wr_ok;
   logic [EW-1:0]       mem [DEPTH];
   logic [EW-1:0]       head;
   logic [PIX_W-1:0]    pix_cnt, pix_inc;
   logic [LINE_W-1:0]   line_cnt, line_inc, line_after;

   // r_fval resets high so SYNC cannot mistake the reset value for a frame gap.
   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge cl_x_pclk or posedge reset) begin
      if (reset) begin
         r_fval <= 1'b1;
         r_lval <= 1'b0;
         r_data <= '0;
      end else begin
         r_fval <= cl_fval;
         r_lval <= cl_x_lval;
         r_data <= {cl_port_j, cl_port_i, cl_port_h, cl_port_g, cl_port_f,
                    cl_port_e, cl_port_d, cl_port_c, cl_port_b, cl_port_a};
      end
   end

   assign beat    = r_fval && r_lval;
   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                    (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
   assign out_valid = !empty;
   assign pop     = out_valid && out_ready;
   assign wr_ok   = !full || pop;
   assign head    = empty ? '0 : mem[rd_ptr[FIFO_AW-1:0]];
   assign {out_sof, out_sol, out_eol, out_data} = head;

   always_ff @(posedge cl_x_pclk or posedge reset) begin
      if (reset) state <= SYNC;
      else       state <= state_n;
   end

   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      state_n    = state;
      load_s     = 1'b0;
      wr_en      = 1'b0;
      wr_fail    = 1'b0;
      frame_done = 1'b0;
      case (state)
         SYNC: if (!r_fval) state_n = IDLE;
         IDLE: if (r_fval) begin
            state_n = FRAME;
            load_s  = beat;
         end
         FRAME: begin
            if (s_full && !wr_ok) begin
               wr_fail = 1'b1;
               state_n = DROP;
            end else begin
               wr_en  = s_full;
               load_s = beat;
               if (!r_fval) begin
                  frame_done = 1'b1;
                  state_n    = IDLE;
               end
            end
         end
         DROP: if (!r_fval) state_n = IDLE;
         default: state_n = SYNC;
      endcase
   end

   assign sof_now    = (state == IDLE) || sof_arm;
   assign eol_wr     = wr_en && !beat;
   assign pix_inc    = (&pix_cnt) ? pix_cnt : pix_cnt + PIX_W'(1);
   assign line_inc   = (&line_cnt) ? line_cnt : line_cnt + LINE_W'(1);
   assign line_after = eol_wr ? line_inc : line_cnt;

   always_ff @(posedge cl_x_pclk or posedge reset) begin
      if (reset) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         s_full      <= 1'b0;
         s_sof       <= 1'b0;
         s_sol       <= 1'b0;
         s_data      <= '0;
         sof_arm     <= 1'b0;
         overflow    <= 1'b0;
         pix_cnt     <= '0;
         line_cnt    <= '0;
         line_pixels <= '0;
         frame_lines <= '0;
         frame_count <= '0;
      end else begin
         if (wr_en)   wr_ptr   <= wr_ptr + 1'b1;
         if (pop)     rd_ptr   <= rd_ptr + 1'b1;
         if (wr_fail) overflow <= 1'b1;
         s_full <= load_s;
         if (load_s) begin
            s_data <= r_data;
            s_sof  <= sof_now;
            s_sol  <= sof_now || !s_full;
         end
         if (state == IDLE) sof_arm <= !load_s;
         else if (load_s)   sof_arm <= 1'b0;
         if (state != FRAME) begin
            pix_cnt  <= load_s ? PIX_W'(1) : '0;
            line_cnt <= '0;
         end else begin
            if (eol_wr) begin
               line_pixels <= pix_cnt;
               pix_cnt     <= '0;
            end else if (load_s) begin
               pix_cnt <= pix_inc;
            end
            if (frame_done) begin
               frame_lines <= line_after;
               line_cnt    <= '0;
               frame_count <= frame_count + 8'd1;
            end else begin
               line_cnt <= line_after;
            end
         end
      end
   end

   // NOTE: FIFO storage is not reset; the empty flag masks stale contents at the head.
   always_ff @(posedge cl_x_pclk) begin
      if (wr_en) mem[wr_ptr[FIFO_AW-1:0]] <= {s_sof, s_sol, !beat, s_data};
   end

   assign state_bits = state;
   assign led8       = {state_bits, overflow, out_valid, frame_count[3:0]};

endmodule

// File: tb/tb_cl_frame_capture.sv
// Directed bench for cl_frame_capture: each task drives one scenario and
// compares the popped entry stream and status outputs with hand-derived values.
module tb_cl_frame_capture;

   typedef logic [82:0] entry_t;

   logic        cl_x_pclk = 1'b0;
   logic        reset = 1'b1;
   logic        cl_fval = 1'b0, cl_x_lval = 1'b0, out_ready = 1'b1;
   logic [79:0] pin = '0;
   logic [79:0] out_data;
   logic        out_sof, out_sol, out_eol, out_valid, overflow;
   logic [11:0] line_pixels, frame_lines;
   logic [7:0]  frame_count, led8;
   entry_t      cur;

   int     total = 0;
   int     bad = 0;
   bit     bp_mode = 1'b0;
   entry_t rx[$];
   entry_t exp_q[$];
   logic   prev_stall = 1'b0;
   entry_t prev_entry = '0;

   cl_frame_capture #(.FIFO_AW(4), .PIX_W(12), .LINE_W(12)) dut (
      .cl_x_pclk(cl_x_pclk), .reset(reset), .cl_fval(cl_fval), .cl_x_lval(cl_x_lval),
      .cl_port_a(pin[7:0]),   .cl_port_b(pin[15:8]),  .cl_port_c(pin[23:16]),
      .cl_port_d(pin[31:24]), .cl_port_e(pin[39:32]), .cl_port_f(pin[47:40]),
      .cl_port_g(pin[55:48]), .cl_port_h(pin[63:56]), .cl_port_i(pin[71:64]),
      .cl_port_j(pin[79:72]),
      .out_data(out_data), .out_sof(out_sof), .out_sol(out_sol), .out_eol(out_eol),
      .out_valid(out_valid), .out_ready(out_ready), .line_pixels(line_pixels),
      .frame_lines(frame_lines), .frame_count(frame_count), .overflow(overflow), .led8(led8)
   );

   always #5 cl_x_pclk = ~cl_x_pclk;
   assign cur = {out_sof, out_sol, out_eol, out_data};

   // Records every pop and checks that a stalled head holds until it is taken.
   always @(negedge cl_x_pclk) begin
      #1;
      if (reset) prev_stall = 1'b0;
      else begin
         if (prev_stall) begin
            total++;
            if (!(out_valid === 1'b1 && cur === prev_entry)) begin
               bad++;
               $display("FAIL stall_hold: got valid=%b entry=%h required valid=1 entry=%h",
                        out_valid, cur, prev_entry);
            end
         end
         if (out_valid === 1'b1 && out_ready === 1'b1) rx.push_back(cur);
         prev_stall = (out_valid === 1'b1) && (out_ready === 1'b0);
         prev_entry = cur;
      end
   end

   function automatic logic [79:0] mk(input int f, input int l, input int b);
      logic [79:0] r;
      for (int k = 0; k < 10; k++) r[k*8 +: 8] = 8'(k*29 + f*11 + l*5 + b + 1);
      return r;
   endfunction

   task automatic cyc(input logic f, input logic l, input logic [79:0] d);
      @(negedge cl_x_pclk);
      cl_fval   = f;
      cl_x_lval = l;
      pin       = d;
      if (bp_mode) out_ready = ~out_ready;
   endtask

   task automatic push(input logic sof, input logic sol, input logic eol, input logic [79:0] d);
      exp_q.push_back({sof, sol, eol, d});
   endtask

   task automatic send_frame(input int f, input int nl, input int nb, input bit fall);
      cyc(1'b1, 1'b0, '0);
      for (int l = 0; l < nl; l++) begin
         for (int b = 0; b < nb; b++) cyc(1'b1, 1'b1, mk(f, l, b));
         if (!(fall && l == nl - 1)) cyc(1'b1, 1'b0, '0);
      end
      repeat (3) cyc(1'b0, 1'b0, '0);
   endtask

   task automatic exp_frame(input int f, input int nl, input int nb);
      for (int l = 0; l < nl; l++)
         for (int b = 0; b < nb; b++)
            push(l == 0 && b == 0, b == 0, b == nb - 1, mk(f, l, b));
   endtask

   task automatic wait_rx(input int n);
      for (int i = 0; i < 300 && rx.size() < n; i++) cyc(1'b0, 1'b0, '0);
      repeat (4) cyc(1'b0, 1'b0, '0);
   endtask

   task automatic test_reset;
      repeat (3) @(negedge cl_x_pclk);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", out_valid); end
      total++; if ({out_sof, out_sol, out_eol} !== 3'b000) begin bad++; $display("FAIL rst_flags: got %b want 000", {out_sof, out_sol, out_eol}); end
      total++; if (out_data !== 80'd0) begin bad++; $display("FAIL rst_data: got %h want 0", out_data); end
      total++; if (line_pixels !== 12'd0) begin bad++; $display("FAIL rst_line_pixels: got %0d want 0", line_pixels); end
      total++; if (frame_lines !== 12'd0) begin bad++; $display("FAIL rst_frame_lines: got %0d want 0", frame_lines); end
      total++; if (frame_count !== 8'd0) begin bad++; $display("FAIL rst_frame_count: got %0d want 0", frame_count); end
      total++; if (overflow !== 1'b0) begin bad++; $display("FAIL rst_overflow: got %b want 0", overflow); end
      total++; if (led8 !== 8'h00) begin bad++; $display("FAIL rst_led8: got %h want 00", led8); end
      reset = 1'b0;
      repeat (3) cyc(1'b0, 1'b0, '0);
      total++; if (led8[7:6] !== 2'b01) begin bad++; $display("FAIL rst_to_idle: got state %b want 01", led8[7:6]); end
   endtask

   task automatic test_clean;
      rx.delete(); exp_q.delete();
      send_frame(1, 3, 4, 1'b0);
      exp_frame(1, 3, 4);
      wait_rx(12);
      total++; if (rx.size() !== 12) begin bad++; $display("FAIL clean_count: got %0d want 12", rx.size()); end
      for (int i = 0; i < exp_q.size() && i < rx.size(); i++) begin
         total++; if (rx[i] !== exp_q[i]) begin bad++; $display("FAIL clean_entry%0d: got %h want %h", i, rx[i], exp_q[i]); end
      end
      total++; if (line_pixels !== 12'd4) begin bad++; $display("FAIL clean_line_pixels: got %0d want 4", line_pixels); end
      total++; if (frame_lines !== 12'd3) begin bad++; $display("FAIL clean_frame_lines: got %0d want 3", frame_lines); end
      total++; if (frame_count !== 8'd1) begin bad++; $display("FAIL clean_frame_count: got %0d want 1", frame_count); end
      total++; if (overflow !== 1'b0) begin bad++; $display("FAIL clean_overflow: got %b want 0", overflow); end
   endtask

   task automatic test_reset_midframe;
      rx.delete(); exp_q.delete();
      out_ready = 1'b0;
      cyc(1'b1, 1'b0, '0);
      for (int b = 0; b < 3; b++) cyc(1'b1, 1'b1, mk(7, 0, b));
      cyc(1'b1, 1'b0, '0);
      cyc(1'b1, 1'b0, '0);
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL mid_prefill: got valid=%b want 1", out_valid); end
      #2 reset = 1'b1;
      #1;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_async_valid: got %b want 0", out_valid); end
      total++; if (out_data !== 80'd0) begin bad++; $display("FAIL mid_async_data: got %h want 0", out_data); end
      total++; if (frame_count !== 8'd0) begin bad++; $display("FAIL mid_async_fc: got %0d want 0", frame_count); end
      total++; if (line_pixels !== 12'd0) begin bad++; $display("FAIL mid_async_lp: got %0d want 0", line_pixels); end
      out_ready = 1'b1;
      cyc(1'b1, 1'b1, mk(7, 1, 0));
      cyc(1'b1, 1'b1, mk(7, 1, 1));
      reset = 1'b0;
      for (int b = 2; b < 4; b++) cyc(1'b1, 1'b1, mk(7, 1, b));
      cyc(1'b1, 1'b0, '0);
      for (int b = 0; b < 4; b++) cyc(1'b1, 1'b1, mk(7, 2, b));
      cyc(1'b1, 1'b0, '0);
      cyc(1'b1, 1'b0, '0);
      total++; if (rx.size() !== 0 || out_valid !== 1'b0) begin bad++; $display("FAIL mid_partial: got %0d entries valid=%b want 0 entries valid=0", rx.size(), out_valid); end
      repeat (3) cyc(1'b0, 1'b0, '0);
      send_frame(8, 2, 2, 1'b0);
      exp_frame(8, 2, 2);
      wait_rx(4);
      total++; if (rx.size() !== 4) begin bad++; $display("FAIL mid_count: got %0d want 4", rx.size()); end
      for (int i = 0; i < exp_q.size() && i < rx.size(); i++) begin
         total++; if (rx[i] !== exp_q[i]) begin bad++; $display("FAIL mid_entry%0d: got %h want %h", i, rx[i], exp_q[i]); end
      end
      total++; if (frame_count !== 8'd1) begin bad++; $display("FAIL mid_frame_count: got %0d want 1", frame_count); end
      total++; if (frame_lines !== 12'd2) begin bad++; $display("FAIL mid_frame_lines: got %0d want 2", frame_lines); end
   endtask

   task automatic test_one_beat_line;
      rx.delete(); exp_q.delete();
      cyc(1'b1, 1'b0, '0);
      cyc(1'b1, 1'b1, mk(9, 0, 0));
      cyc(1'b1, 1'b0, '0);
      cyc(1'b1, 1'b1, mk(9, 1, 0));
      cyc(1'b1, 1'b1, mk(9, 1, 1));
      cyc(1'b1, 1'b0, '0);
      repeat (3) cyc(1'b0, 1'b0, '0);
      push(1'b1, 1'b1, 1'b1, mk(9, 0, 0));
      push(1'b0, 1'b1, 1'b0, mk(9, 1, 0));
      push(1'b0, 1'b0, 1'b1, mk(9, 1, 1));
      wait_rx(3);
      total++; if (rx.size() !== 3) begin bad++; $display("FAIL one_count: got %0d want 3", rx.size()); end
      for (int i = 0; i < exp_q.size() && i < rx.size(); i++) begin
         total++; if (rx[i] !== exp_q[i]) begin bad++; $display("FAIL one_entry%0d: got %h want %h", i, rx[i], exp_q[i]); end
      end
      total++; if (line_pixels !== 12'd2) begin bad++; $display("FAIL one_line_pixels: got %0d want 2", line_pixels); end
      total++; if (frame_lines !== 12'd2) begin bad++; $display("FAIL one_frame_lines: got %0d want 2", frame_lines); end
      total++; if (frame_count !== 8'd2) begin bad++; $display("FAIL one_frame_count: got %0d want 2", frame_count); end
   endtask

   task automatic test_fall_with_lval;
      rx.delete(); exp_q.delete();
      send_frame(10, 2, 3, 1'b1);
      exp_frame(10, 2, 3);
      wait_rx(6);
      total++; if (rx.size() !== 6) begin bad++; $display("FAIL fall_count: got %0d want 6", rx.size()); end
      for (int i = 0; i < exp_q.size() && i < rx.size(); i++) begin
         total++; if (rx[i] !== exp_q[i]) begin bad++; $display("FAIL fall_entry%0d: got %h want %h", i, rx[i], exp_q[i]); end
      end
      total++; if (frame_count !== 8'd3) begin bad++; $display("FAIL fall_frame_count: got %0d want 3", frame_count); end
      total++; if (frame_lines !== 12'd2) begin bad++; $display("FAIL fall_frame_lines: got %0d want 2", frame_lines); end
      total++; if (line_pixels !== 12'd3) begin bad++; $display("FAIL fall_line_pixels: got %0d want 3", line_pixels); end
   endtask

   task automatic test_back_to_back_backpressure;
      rx.delete(); exp_q.delete();
      bp_mode = 1'b1;
      send_frame(11, 2, 8, 1'b0);
      exp_frame(11, 2, 8);
      wait_rx(16);
      bp_mode = 1'b0;
      out_ready = 1'b1;
      total++; if (rx.size() !== 16) begin bad++; $display("FAIL bp_count: got %0d want 16", rx.size()); end
      for (int i = 0; i < exp_q.size() && i < rx.size(); i++) begin
         total++; if (rx[i] !== exp_q[i]) begin bad++; $display("FAIL bp_entry%0d: got %h want %h", i, rx[i], exp_q[i]); end
      end
      total++; if (overflow !== 1'b0) begin bad++; $display("FAIL bp_overflow: got %b want 0", overflow); end
      total++; if (led8[3:0] !== 4'd4) begin bad++; $display("FAIL bp_led_fc: got %0d want 4", led8[3:0]); end
      total++; if (line_pixels !== 12'd8) begin bad++; $display("FAIL bp_line_pixels: got %0d want 8", line_pixels); end
   endtask

   task automatic test_overflow;
      rx.delete(); exp_q.delete();
      out_ready = 1'b0;
      cyc(1'b1, 1'b0, '0);
      for (int b = 0; b < 20; b++) cyc(1'b1, 1'b1, mk(12, 0, b));
      cyc(1'b1, 1'b0, '0);
      cyc(1'b1, 1'b0, '0);
      total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag: got %b want 1", overflow); end
      total++; if (led8[7:6] !== 2'b11) begin bad++; $display("FAIL ovf_state: got %b want 11", led8[7:6]); end
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL ovf_valid: got %b want 1", out_valid); end
      repeat (3) cyc(1'b0, 1'b0, '0);
      total++; if (led8[7:6] !== 2'b01) begin bad++; $display("FAIL ovf_idle: got %b want 01", led8[7:6]); end
      total++; if (frame_count !== 8'd4) begin bad++; $display("FAIL ovf_frame_count: got %0d want 4", frame_count); end
      total++; if (frame_lines !== 12'd2) begin bad++; $display("FAIL ovf_frame_lines: got %0d want 2", frame_lines); end
      for (int k = 0; k < 16; k++) push(k == 0, k == 0, 1'b0, mk(12, 0, k));
      out_ready = 1'b1;
      wait_rx(16);
      total++; if (rx.size() !== 16) begin bad++; $display("FAIL ovf_count: got %0d want 16", rx.size()); end
      for (int i = 0; i < exp_q.size() && i < rx.size(); i++) begin
         total++; if (rx[i] !== exp_q[i]) begin bad++; $display("FAIL ovf_entry%0d: got %h want %h", i, rx[i], exp_q[i]); end
      end
      total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
   endtask

   initial begin
      test_reset();
      test_clean();
      test_reset_midframe();
      test_one_beat_line();
      test_fall_with_lval();
      test_back_to_back_backpressure();
      test_overflow();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
